// File: rtl/a_chan_pkg.sv
// Shared types and default sizes for the A-channel arbiter.
package a_chan_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int OPC_W_DEF   = 4;
    localparam int DATA_W_DEF  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } a_state_t;

    typedef logic [OPC_W_DEF-1:0] opcode_t;

endpackage

// File: rtl/a_chan_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after rr_ptr, wrapping.
module rr_pick
    import a_chan_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      rr_ptr,
    output logic               any,
    output logic [IW-1:0]      winner
);

    // Scan from the farthest offset down so the closest one to rr_ptr wins.
    always_comb begin
        any    = 1'b0;
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[(int'(rr_ptr) + i) % NUM_REQ]) begin
                any    = 1'b1;
                winner = IW'((int'(rr_ptr) + i) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/a_chan_arbiter.sv
// Round-robin arbiter granting whole bursts of a shared A channel to one requester.
//   state | meaning
//   IDLE  | no owner; arbitrate among req_valid, grant takes effect next cycle
//   BURST | owner grant_id streams len+1 beats to the A channel
module a_chan_arbiter
    import a_chan_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int OPC_W   = OPC_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*OPC_W-1:0]  req_opcode,
    input  logic [NUM_REQ*2-1:0]      req_len,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      a_valid,
    input  logic                      a_ready,
    output logic [OPC_W-1:0]          a_opcode,
    output logic [1:0]                a_beat,
    output logic [DATA_W-1:0]         a_data,
    output logic [IW-1:0]             grant_id,
    output logic                      busy,
    output logic [31:0]               burst_count
);

    a_state_t          state_q, state_d;
    logic [IW-1:0]     rr_q, rr_d;
    logic [IW-1:0]     gid_q, gid_d;
    logic [OPC_W-1:0]  opc_q, opc_d;
    logic [1:0]        len_q, len_d;
    logic [1:0]        beat_q, beat_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic              pick_any;
    logic [IW-1:0]     pick_id;
    logic [DATA_W-1:0] owner_data;
    logic              xfer;

    rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr_pick (
        .req    (req_valid),
        .rr_ptr (rr_q),
        .any    (pick_any),
        .winner (pick_id)
    );

    assign owner_data = req_data[int'(gid_q)*DATA_W +: DATA_W];
    assign busy       = (state_q == BURST);
    assign a_valid    = busy && req_valid[gid_q];
    assign xfer       = a_valid && a_ready;

    assign a_opcode    = opc_q;
    assign a_beat      = beat_q;
    assign grant_id    = gid_q;
    assign burst_count = cnt_q;
    // Data is live during a burst; in IDLE it shows the last owner beat seen.
    assign a_data      = busy ? owner_data : data_q;

    always_comb begin
        req_ready = '0;
        if (busy) begin
            req_ready[gid_q] = a_ready;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gid_d   = gid_q;
        opc_d   = opc_q;
        len_d   = len_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = BURST;
                    gid_d   = pick_id;
                    opc_d   = req_opcode[int'(pick_id)*OPC_W +: OPC_W];
                    len_d   = req_len[int'(pick_id)*2 +: 2];
                    beat_d  = 2'd0;
                end
            end
            BURST: begin
                data_d = owner_data;
                if (xfer) begin
                    // Last beat keeps the counter so a_beat holds its final index in IDLE.
                    if (beat_q == len_q) begin
                        state_d = IDLE;
                        rr_d    = (int'(gid_q) == NUM_REQ - 1) ? '0 : gid_q + 1'b1;
                        cnt_d   = cnt_q + 32'd1;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rr_q    <= '0;
            gid_q   <= '0;
            opc_q   <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gid_q   <= gid_d;
            opc_q   <= opc_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_a_chan_arbiter.sv
// Self-checking bench for a_chan_arbiter: directed scenarios plus random traffic vs a burst-level model.
module tb_a_chan_arbiter;

    localparam int N  = 4;
    localparam int OW = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*OW-1:0] req_opcode;
    logic [N*2-1:0]  req_len;
    logic [N*DW-1:0] req_data;
    logic            a_valid;
    logic            a_ready;
    logic [OW-1:0]   a_opcode;
    logic [1:0]      a_beat;
    logic [DW-1:0]   a_data;
    logic [1:0]      grant_id;
    logic            busy;
    logic [31:0]     burst_count;

    logic [OW-1:0]   opc_in [N];
    logic [1:0]      len_in [N];
    logic [DW-1:0]   dat_in [N];

    int n_checks = 0;
    int n_fail   = 0;

    // Burst-level model: who owns the channel, how far into the burst, what was latched.
    bit          m_init = 0;
    int          m_owner;
    int          m_rr;
    int          m_gid;
    int          m_beat;
    int          m_len;
    logic [OW-1:0] m_opc;
    logic [DW-1:0] m_data;
    logic [31:0] m_count;

    a_chan_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_opcode  (req_opcode),
        .req_len     (req_len),
        .req_data    (req_data),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_opcode    (a_opcode),
        .a_beat      (a_beat),
        .a_data      (a_data),
        .grant_id    (grant_id),
        .busy        (busy),
        .burst_count (burst_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_opcode = '0;
        req_len    = '0;
        req_data   = '0;
        for (int i = 0; i < N; i++) begin
            req_opcode[i*OW +: OW] = opc_in[i];
            req_len[i*2 +: 2]      = len_in[i];
            req_data[i*DW +: DW]   = dat_in[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] e_rdy;
        bit           e_busy;
        if (!m_init) return;
        e_busy = (m_owner >= 0);
        e_rdy  = '0;
        if (e_busy && a_ready) e_rdy[m_owner] = 1'b1;
        chk("busy",        busy,        e_busy);
        chk("a_valid",     a_valid,     e_busy && req_valid[m_owner]);
        chk("req_ready",   req_ready,   e_rdy);
        chk("grant_id",    grant_id,    m_gid);
        chk("a_opcode",    a_opcode,    m_opc);
        chk("a_beat",      a_beat,      m_beat);
        chk("a_data",      a_data,      e_busy ? dat_in[m_owner] : m_data);
        chk("burst_count", burst_count, m_count);
    endtask

    task automatic update_model();
        bit found;
        int idx;
        if (reset) begin
            m_init  = 1;
            m_owner = -1;
            m_rr    = 0;
            m_gid   = 0;
            m_beat  = 0;
            m_len   = 0;
            m_opc   = '0;
            m_data  = '0;
            m_count = '0;
            return;
        end
        if (!m_init) return;
        if (m_owner < 0) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (!found && req_valid[idx]) begin
                    found   = 1;
                    m_owner = idx;
                    m_gid   = idx;
                    m_opc   = opc_in[idx];
                    m_len   = len_in[idx];
                    m_beat  = 0;
                end
            end
        end else begin
            m_data = dat_in[m_owner];
            if (req_valid[m_owner] && a_ready) begin
                if (m_beat == m_len) begin
                    m_rr    = (m_owner + 1) % N;
                    m_owner = -1;
                    m_count = m_count + 1;
                end else begin
                    m_beat++;
                end
            end
        end
    endtask

    // Inputs are set just after a rising edge; outputs are checked at the falling edge.
    task automatic run_cycle();
        for (int i = 0; i < N; i++) dat_in[i] = DW'($urandom);
        #4;
        check_outputs();
        update_model();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [N-1:0] v, input logic [1:0] len, input logic [OW-1:0] opc);
        req_valid = v;
        for (int i = 0; i < N; i++) begin
            len_in[i] = len;
            opc_in[i] = opc;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_all('0, 2'd0, '0);
        run_cycle();
        run_cycle();
        reset = 1'b0;
    endtask

    int grants[$];
    bit prev_busy;

    initial begin
        reset   = 1'b1;
        a_ready = 1'b0;
        set_all('0, 2'd0, '0);
        for (int i = 0; i < N; i++) dat_in[i] = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Single requester, 3-beat burst.
        a_ready = 1'b1;
        set_all(4'b0001, 2'd2, 4'h5);
        for (int c = 0; c < 6; c++) run_cycle();
        set_all('0, 2'd0, '0);
        run_cycle();

        // All requesters, single-beat bursts: grant order and idle gaps.
        do_reset();
        set_all(4'b1111, 2'd0, 4'h1);
        prev_busy = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #4;
            if (busy && !prev_busy) grants.push_back(int'(grant_id));
            if (c > 0) chk("alt_busy", busy, c % 2 == 0 ? 0 : 1);
            prev_busy = busy;
            #1;
            update_model();
            @(posedge clk);
            #1;
        end
        chk("grant_cnt", grants.size(), 5);
        for (int g = 0; g < 5 && g < grants.size(); g++) chk("grant_order", grants[g], g % N);

        // Ready toggling during a 4-beat burst.
        do_reset();
        set_all(4'b0010, 2'd3, 4'h9);
        for (int c = 0; c < 10; c++) begin
            a_ready = c[0];
            run_cycle();
        end
        a_ready = 1'b1;
        set_all('0, 2'd0, '0);
        run_cycle();

        // Owner stalls mid-burst while requester 2 waits.
        do_reset();
        set_all(4'b0101, 2'd3, 4'h2);
        for (int c = 0; c < 3; c++) run_cycle();
        req_valid = 4'b0100;
        for (int c = 0; c < 3; c++) run_cycle();
        req_valid = 4'b0101;
        for (int c = 0; c < 5; c++) run_cycle();
        req_valid = 4'b0100;
        for (int c = 0; c < 4; c++) run_cycle();

        // Reset in the middle of a burst, then full contention.
        do_reset();
        set_all(4'b0001, 2'd3, 4'h4);
        for (int c = 0; c < 2; c++) run_cycle();
        reset = 1'b1;
        run_cycle();
        reset = 1'b0;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_cnt", burst_count, 0);
        set_all(4'b1111, 2'd1, 4'h6);
        for (int c = 0; c < 4; c++) run_cycle();

        // Opcode change after grant is ignored.
        do_reset();
        set_all(4'b0001, 2'd3, 4'h3);
        run_cycle();
        for (int i = 0; i < N; i++) opc_in[i] = 4'h7;
        for (int c = 0; c < 4; c++) begin
            chk("opc_hold", a_opcode, 4'h3);
            run_cycle();
        end

        // Random traffic.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 199) == 0);
            req_valid = N'($urandom) | N'($urandom);
            a_ready   = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                opc_in[i] = OW'($urandom);
                len_in[i] = 2'($urandom);
            end
            run_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
